// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues in-order instruction fetches, follows the branch predictor,
// writes returned instructions into the instruction buffer and handles backend redirects.
module fetch_ctrl #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           DEPTH           = 8,
  parameter int unsigned           MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   bp_taken,
  input  logic [ADDR_WIDTH-1:0]  bp_target,
  output logic [ADDR_WIDTH-1:0]  fetch_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]  imem_rsp_data,
  input  logic [$clog2(DEPTH):0] ibuf_count,
  output logic                   ibuf_wen,
  output logic [DATA_WIDTH-1:0]  ibuf_inst,
  output logic [ADDR_WIDTH-1:0]  ibuf_pc,
  output logic                   ibuf_pred,
  output logic                   ibuf_clr
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(DEPTH);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [OUT_W-1:0]        outstanding_q, outstanding_d;
  logic [OUT_W-1:0]        drop_cnt_q, drop_cnt_d;
  logic [OUT_W-1:0]        remaining;

  logic [ADDR_WIDTH-1:0]   tag_pc   [MAX_OUTSTANDING];
  logic                    tag_pred [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        tag_wr_q, tag_rd_q;
  logic [OUT_W-1:0]        tag_cnt_q;

  logic redirect;
  logic credit_ok;
  logic req_valid;
  logic issue;
  logic accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Redirects are ignored in BOOT; everywhere else they win over issue and write.
  assign redirect  = !rst && redirect_valid && (state_q != BOOT);

  // An in-flight request already owns a buffer slot, so it counts against the credit.
  assign credit_ok = ((SUM_W'(ibuf_count) + SUM_W'(outstanding_q)) < DEPTH_S) &&
                     (outstanding_q < OUT_MAX);
  assign req_valid = !rst && (state_q == FETCH) && credit_ok && !redirect_valid;
  assign issue     = req_valid && imem_req_ready;
  assign accept    = !rst && (state_q == FETCH) && (drop_cnt_q == '0) &&
                     imem_rsp_valid && !redirect_valid;
  assign remaining = outstanding_q - OUT_W'(imem_rsp_valid);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    unique case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (issue) pc_d = bp_taken ? bp_target : pc_q + ADDR_WIDTH'(4);
        if (issue && !accept)      outstanding_d = outstanding_q + OUT_W'(1);
        else if (accept && !issue) outstanding_d = outstanding_q - OUT_W'(1);
      end
      DRAIN: begin
        if (imem_rsp_valid) begin
          drop_cnt_d    = drop_cnt_q - OUT_W'(1);
          outstanding_d = outstanding_q - OUT_W'(1);
          if (drop_cnt_q == OUT_W'(1)) state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase

    // Every request still in flight after this cycle belongs to the squashed path.
    if (redirect) begin
      pc_d          = redirect_pc;
      drop_cnt_d    = remaining;
      outstanding_d = remaining;
      state_d       = (remaining != '0) ? DRAIN : FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
    end else begin
      if (issue)  tag_wr_q <= ptr_inc(tag_wr_q);
      if (accept) tag_rd_q <= ptr_inc(tag_rd_q);
      tag_cnt_q <= tag_cnt_q + OUT_W'(issue) - OUT_W'(accept);
    end
  end

  // NOTE: the tag storage has no reset; entries are only read after being written, and the pointers are reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_pc[tag_wr_q]   <= pc_q;
      tag_pred[tag_wr_q] <= bp_taken;
    end
  end

  assign fetch_pc       = rst ? '0 : pc_q;
  assign imem_req_addr  = rst ? '0 : pc_q;
  assign imem_req_valid = req_valid;
  assign ibuf_wen       = accept;
  assign ibuf_inst      = accept ? imem_rsp_data : '0;
  assign ibuf_pc        = accept ? tag_pc[tag_rd_q] : '0;
  assign ibuf_pred      = accept && tag_pred[tag_rd_q];
  assign ibuf_clr       = redirect;

  a_rsp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outstanding_q == '0)));
  a_tag_overflow: assert property (@(posedge clk) disable iff (rst)
    !(issue && !accept && (tag_cnt_q == OUT_MAX)));
  a_tag_underflow: assert property (@(posedge clk) disable iff (rst)
    !(accept && (tag_cnt_q == '0)));
  a_ibuf_overflow: assert property (@(posedge clk) disable iff (rst)
    !(ibuf_wen && (ibuf_count == CNT_FULL)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: a memory model, a buffer-occupancy model and an
// expected-instruction queue drained by an independent write monitor.
module tb_fetch_ctrl;

  localparam int          DEPTH    = 8;
  localparam int          MAXO     = 4;
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          bp_taken;
  logic [31:0]   bp_target;
  logic [31:0]   fetch_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic [CW-1:0] ibuf_count;
  logic          ibuf_wen;
  logic [31:0]   ibuf_inst;
  logic [31:0]   ibuf_pc;
  logic          ibuf_pred;
  logic          ibuf_clr;

  fetch_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bp_taken(bp_taken), .bp_target(bp_target), .fetch_pc(fetch_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .ibuf_count(ibuf_count),
    .ibuf_wen(ibuf_wen), .ibuf_inst(ibuf_inst), .ibuf_pc(ibuf_pc),
    .ibuf_pred(ibuf_pred), .ibuf_clr(ibuf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic [31:0] inst;
  } exp_t;

  mem_t mem_q[$];
  exp_t exp_q[$];
  exp_t cur;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch = 0;
  int buf_cnt = 0;
  int writes_seen = 0;
  int max_inflight = 0;
  int redir_stage = 0;
  int fired = 0;
  int seen_target = 0;
  logic [31:0] model_pc = RESET_PC;
  logic        boot = 1'b1;
  logic        rd = 1'b0;
  logic        rst_req = 1'b1;

  int lat_min, lat_max, ready_pct, rsp_pct, rd_pct, bp_mode, redir_mode, redir_pct;
  logic hold_zero;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic knobs(input int lmin, input int lmax, input int rdy, input int rsp,
                       input int rdp, input int bpm, input int rdm, input int rdr,
                       input logic hz);
    lat_min = lmin; lat_max = lmax; ready_pct = rdy; rsp_pct = rsp; rd_pct = rdp;
    bp_mode = bpm; redir_mode = rdm; redir_pct = rdr; hold_zero = hz;
  endtask

  task automatic drive();
    int st;
    rst            = rst_req;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst && mem_q.size() > 0 && mem_q[0].ready <= cyc && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_q[0].addr);
    end
    bp_target = (model_pc & 32'hFFFF_F000) | ($urandom & 32'h0000_0FFC);
    bp_taken  = 1'b0;
    if (bp_mode == 1 && model_pc == 32'h8000_0008) begin
      bp_taken  = 1'b1;
      bp_target = 32'h8000_0100;
    end else if (bp_mode == 2) begin
      bp_taken = ($urandom_range(99) < 25);
    end
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    st = stale_cnt();
    if (!rst && redir_mode == 1 && $urandom_range(99) < redir_pct) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
    end else if (!rst && redir_mode == 2) begin
      if (redir_stage == 0 && !boot && st == 0 && mem_q.size() == 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        redir_stage    = 1;
      end else if (redir_stage == 1 && st == 2 && imem_rsp_valid) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_3000;
        redir_stage    = 2;
      end
    end
    rd         = !hold_zero && buf_cnt > 0 && ($urandom_range(99) < rd_pct);
    ibuf_count = hold_zero ? '0 : CW'(buf_cnt);
  endtask

  task automatic observe();
    int   inflight, st;
    logic exp_valid, exp_clr, exp_wen;
    mem_t m;
    exp_t e;
    inflight  = mem_q.size();
    st        = stale_cnt();
    exp_clr   = !rst && !boot && redirect_valid;
    exp_valid = !rst && !boot && !redirect_valid && st == 0 &&
                (buf_cnt + inflight < DEPTH) && inflight < MAXO;
    exp_wen   = 1'b0;
    if (!rst && imem_rsp_valid && !redirect_valid) exp_wen = (mem_q[0].epoch == epoch);

    if (rst) begin
      check("rst_outputs", |{fetch_pc, imem_req_valid, imem_req_addr, ibuf_wen,
                             ibuf_inst, ibuf_pc, ibuf_pred, ibuf_clr}, 1'b0);
    end else begin
      check("req_valid", imem_req_valid, exp_valid);
      check("fetch_pc", fetch_pc, model_pc);
      if (exp_valid) check("req_addr", imem_req_addr, model_pc);
      check("ibuf_clr", ibuf_clr, exp_clr);
      check("ibuf_wen", ibuf_wen, exp_wen);
    end

    // Advance the reference to the state after the coming edge.
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      buf_cnt  = 0;
      model_pc = RESET_PC;
    end else begin
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        m.addr  = imem_req_addr;
        m.epoch = epoch;
        m.ready = cyc + int'($urandom_range(lat_max, lat_min));
        mem_q.push_back(m);
        if (mem_q.size() > max_inflight) max_inflight = mem_q.size();
        if (imem_req_addr == 32'h8000_0100) seen_target = 1;
      end
      if (exp_valid && imem_req_ready) begin
        e.pc   = model_pc;
        e.pred = bp_taken;
        e.inst = mem_data(model_pc);
        exp_q.push_back(e);
        model_pc = bp_taken ? bp_target : model_pc + 32'd4;
      end
      if (exp_clr) begin
        epoch++;
        model_pc = redirect_pc;
        exp_q.delete();
      end
      if (ibuf_clr || hold_zero) buf_cnt = 0;
      else buf_cnt = buf_cnt + int'(ibuf_wen) - int'(rd);
    end
    boot = rst;
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    observe();
    cyc++;
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
  endtask

  // Write monitor: every buffer write must match the oldest surviving issued fetch.
  always @(negedge clk) begin
    #2;
    if (ibuf_wen) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected actual pc=%0h required=no write cycle=%0d", ibuf_pc, cyc);
      end else begin
        cur = exp_q.pop_front();
        check("wr_pc", ibuf_pc, cur.pc);
        check("wr_pred", ibuf_pred, cur.pred);
        check("wr_inst", ibuf_inst, cur.inst);
      end
    end
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; bp_taken = 1'b0; bp_target = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; ibuf_count = '0;
    knobs(1, 1, 100, 100, 0, 0, 0, 0, 1'b0);

    // Sequential fill with a 1-cycle memory and no buffer reads.
    do_reset();
    writes_seen = 0;
    repeat (40) step();
    #3;
    check("p1_writes", writes_seen, 8);

    // Predicted-taken branch at 0x8000_0008.
    knobs(1, 1, 100, 100, 50, 1, 0, 0, 1'b0);
    do_reset();
    seen_target = 0;
    repeat (40) step();
    check("p2_target_req", seen_target, 1);

    // Long latency with the buffer always empty: in-flight limit governs.
    knobs(5, 5, 100, 100, 0, 0, 0, 0, 1'b1);
    do_reset();
    max_inflight = 0;
    repeat (40) step();
    check("p3_max_inflight", max_inflight, MAXO);

    // Redirect with 3 in flight, then a second redirect while draining.
    knobs(3, 3, 100, 100, 0, 0, 2, 0, 1'b1);
    do_reset();
    redir_stage = 0;
    repeat (40) step();
    check("p4_redirects", redir_stage, 2);

    // Reset with requests in flight and a partly filled buffer.
    knobs(3, 3, 100, 100, 0, 0, 0, 0, 1'b0);
    do_reset();
    fired = 0;
    for (int i = 0; i < 60 && fired == 0; i++) begin
      if (mem_q.size() == 2 && buf_cnt >= 4) fired = 1;
      else step();
    end
    check("p5_rst_trigger", fired, 1);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    repeat (20) step();

    // Fully random traffic with redirects and occasional resets.
    knobs(1, 6, 70, 80, 40, 2, 1, 4, 1'b0);
    do_reset();
    repeat (3000) begin
      rst_req = ($urandom_range(999) < 4);
      step();
    end
    rst_req = 1'b0;
    repeat (20) step();
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
